spi_frame_master: RTL and testbench

- Initiator end of the single-clock SPI link; drives SS_n/MOSI toward the SPI slave wrapper and samples MISO.
- Accepts one command per valid/ready handshake and serialises it as a slave frame: write-address, write-data, read-address or read-data.
- For read-data, captures the 8-bit MISO response and presents it on a one-cycle valid strobe.
- Sits between the test/host-side controller and the slave wrapper.

---
 rtl/spi_frame_master.sv | 185 ++++++++++++++++++
 tb/tb_spi_frame_master.sv | 336 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_frame_master.sv
// spi_frame_master
//   Initiator side of the single-clock SPI link. Takes one command per
//   valid/ready handshake and serialises it to the slave wrapper as an
//   11-bit frame (select bit, 2-bit type, 8-bit payload, MSB first).
//   Read-data frames (type 11) then wait RD_WAIT cycles and shift in an
//   8-bit response from MISO.
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous active-high reset
//   cmd_valid  command request
//   cmd_ready  high in IDLE once the inter-frame gap has elapsed
//   cmd_type   00 wr-addr, 01 wr-data, 10 rd-addr, 11 rd-data
//   cmd_data   8-bit payload (still shifted out for type 11)
//   SS_n       slave select, active low, registered
//   MOSI       serial data to slave, registered
//   MISO       serial data from slave, sampled only while receiving
//   rd_data    last captured read byte
//   rd_valid   one-cycle strobe when rd_data updates
//   busy       high while a frame or the gap that follows it is in progress
//   seq_err    one-cycle strobe: type 11 accepted with no type 10 pending
module spi_frame_master #(
    parameter int RD_WAIT = 2,
    parameter int GAP     = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       cmd_valid,
    output logic       cmd_ready,
    input  logic [1:0] cmd_type,
    input  logic [7:0] cmd_data,
    output logic       SS_n,
    output logic       MOSI,
    input  logic       MISO,
    output logic [7:0] rd_data,
    output logic       rd_valid,
    output logic       busy,
    output logic       seq_err
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CMD,
        S_SHIFT,
        S_WAIT,
        S_RECV,
        S_GAP
    } state_t;

    localparam logic [3:0] L_WAIT_LAST = 4'(RD_WAIT - 1);
    localparam logic [3:0] L_GAP_INIT  = 4'(GAP);
    localparam logic [3:0] L_GAP_LOAD  = 4'(GAP - 1);
    // The final gap cycle is spent in IDLE with cmd_ready already high, so a
    // waiting command is accepted exactly GAP cycles after SS_n rises. With
    // GAP=1 that means the frame ends straight into IDLE.
    localparam state_t     L_AFTER     = (GAP > 1) ? S_GAP : S_IDLE;

    state_t     r_state;
    state_t     w_next;
    logic [9:0] r_sr;
    logic [6:0] r_rx;
    logic [3:0] r_cnt;
    logic [3:0] r_gap_cnt;
    logic       r_is_read;
    logic       r_addr_pend;
    logic       r_ss_n;
    logic       r_mosi;
    logic [7:0] r_rd_data;
    logic       r_rd_valid;
    logic       r_seq_err;
    logic       w_accept;
    logic       w_shift_last;
    logic       w_recv_last;

    assign cmd_ready    = (r_state == S_IDLE) && (r_gap_cnt == 4'd0);
    assign w_accept     = cmd_valid && cmd_ready;
    assign w_shift_last = (r_state == S_SHIFT) && (r_cnt == 4'd9);
    assign w_recv_last  = (r_state == S_RECV) && (r_cnt == 4'd7);

    assign SS_n     = r_ss_n;
    assign MOSI     = r_mosi;
    assign rd_data  = r_rd_data;
    assign rd_valid = r_rd_valid;
    assign seq_err  = r_seq_err;
    assign busy     = (r_state != S_IDLE) || !r_ss_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_next = S_CMD;
            S_CMD:   w_next = S_SHIFT;
            S_SHIFT: if (r_cnt == 4'd9) w_next = r_is_read ? S_WAIT : L_AFTER;
            S_WAIT:  if (r_cnt == L_WAIT_LAST) w_next = S_RECV;
            S_RECV:  if (r_cnt == 4'd7) w_next = L_AFTER;
            S_GAP:   if (r_gap_cnt <= 4'd1) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    // Control and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ss_n      <= 1'b1;
            r_mosi      <= 1'b0;
            r_rd_data   <= 8'd0;
            r_rd_valid  <= 1'b0;
            r_seq_err   <= 1'b0;
            r_gap_cnt   <= L_GAP_INIT;
            r_cnt       <= 4'd0;
            r_is_read   <= 1'b0;
            r_addr_pend <= 1'b0;
        end else begin
            r_rd_valid <= 1'b0;
            r_seq_err  <= 1'b0;
            if ((r_state == S_IDLE || r_state == S_GAP) && r_gap_cnt != 4'd0) begin
                r_gap_cnt <= r_gap_cnt - 4'd1;
            end
            case (r_state)
                S_IDLE: begin
                    if (w_accept) begin
                        r_ss_n    <= 1'b0;
                        r_mosi    <= cmd_type[1];
                        r_cnt     <= 4'd0;
                        r_is_read <= &cmd_type;
                        r_seq_err <= (&cmd_type) && !r_addr_pend;
                        if (cmd_type == 2'b10) begin
                            r_addr_pend <= 1'b1;
                        end else if (cmd_type == 2'b11) begin
                            r_addr_pend <= 1'b0;
                        end
                    end
                end
                S_CMD: r_mosi <= r_sr[9];
                S_SHIFT: begin
                    if (w_shift_last) begin
                        r_mosi <= 1'b0;
                        r_cnt  <= 4'd0;
                        if (!r_is_read) begin
                            r_ss_n    <= 1'b1;
                            r_gap_cnt <= L_GAP_LOAD;
                        end
                    end else begin
                        r_mosi <= r_sr[9];
                        r_cnt  <= r_cnt + 4'd1;
                    end
                end
                S_WAIT: r_cnt <= (r_cnt == L_WAIT_LAST) ? 4'd0 : r_cnt + 4'd1;
                S_RECV: begin
                    if (w_recv_last) begin
                        r_rd_data  <= {r_rx, MISO};
                        r_rd_valid <= 1'b1;
                        r_ss_n     <= 1'b1;
                        r_gap_cnt  <= L_GAP_LOAD;
                    end else begin
                        r_cnt <= r_cnt + 4'd1;
                    end
                end
                default: ;
            endcase
        end
    end

    // Data-only shift registers. The select bit is driven straight from
    // cmd_type[1] at acceptance, so only {type, data} needs to be held; it
    // moves up one place for every bit put on MOSI.
    always_ff @(posedge clk) begin
        if (r_state == S_IDLE && w_accept) begin
            r_sr <= {cmd_type, cmd_data};
        end else if (r_state == S_CMD || (r_state == S_SHIFT && !w_shift_last)) begin
            r_sr <= {r_sr[8:0], 1'b0};
        end
        if (r_state == S_RECV) begin
            r_rx <= {r_rx[5:0], MISO};
        end
    end

endmodule

// File: tb/tb_spi_frame_master.sv
module tb_spi_frame_master;

    localparam int RW0 = 2;
    localparam int G0  = 1;
    localparam int RW1 = 5;
    localparam int G1  = 3;

    logic       clk = 1'b0;
    logic       rst;
    logic       cvalid [2];
    logic [1:0] ctype  [2];
    logic [7:0] cdata  [2];
    logic       miso   [2];
    logic       cready [2];
    logic       ss_n   [2];
    logic       mosi   [2];
    logic [7:0] rdd    [2];
    logic       rdv    [2];
    logic       busy   [2];
    logic       serr   [2];

    always #5 clk = ~clk;

    spi_frame_master #(.RD_WAIT(RW0), .GAP(G0)) u_dut0 (
        .clk(clk), .rst(rst), .cmd_valid(cvalid[0]), .cmd_ready(cready[0]),
        .cmd_type(ctype[0]), .cmd_data(cdata[0]), .SS_n(ss_n[0]), .MOSI(mosi[0]),
        .MISO(miso[0]), .rd_data(rdd[0]), .rd_valid(rdv[0]), .busy(busy[0]),
        .seq_err(serr[0])
    );

    spi_frame_master #(.RD_WAIT(RW1), .GAP(G1)) u_dut1 (
        .clk(clk), .rst(rst), .cmd_valid(cvalid[1]), .cmd_ready(cready[1]),
        .cmd_type(ctype[1]), .cmd_data(cdata[1]), .SS_n(ss_n[1]), .MOSI(mosi[1]),
        .MISO(miso[1]), .rd_data(rdd[1]), .rd_valid(rdv[1]), .busy(busy[1]),
        .seq_err(serr[1])
    );

    function automatic int rw(input int k);
        return (k == 1) ? RW1 : RW0;
    endfunction

    function automatic int gp(input int k);
        return (k == 1) ? G1 : G0;
    endfunction

    int n_cmp = 0;
    int n_err = 0;

    // Observations gathered once per cycle on the falling edge
    int          cur_len  [2] = '{0, 0};
    logic [63:0] cur_bits [2] = '{64'd0, 64'd0};
    logic        in_fr    [2] = '{1'b0, 1'b0};
    int          hi_cnt   [2] = '{0, 0};
    int          fr_start [2] = '{0, 0};
    int          fr_done  [2] = '{0, 0};
    int          fr_len   [2] = '{0, 0};
    logic [63:0] fr_bits  [2] = '{64'd0, 64'd0};
    int          gap_len  [2] = '{0, 0};
    logic        fr_seq   [2] = '{1'b0, 1'b0};
    logic        fr_rdv_end   [2] = '{1'b0, 1'b0};
    logic        fr_ready_end [2] = '{1'b0, 1'b0};
    logic [7:0]  fr_rdd   [2] = '{8'd0, 8'd0};
    int          rdv_cnt  [2] = '{0, 0};
    int          seq_cnt  [2] = '{0, 0};
    int          busy_bad [2] = '{0, 0};
    logic [7:0]  slave_byte [2] = '{8'd0, 8'd0};
    logic        pend     [2] = '{1'b0, 1'b0};

    // Slave model and frame monitor: the response byte is presented MSB first
    // during the 8 cycles that end when SS_n rises; every other cycle carries
    // random noise on MISO.
    always @(negedge clk) begin
        for (int k = 0; k < 2; k++) begin
            if (rst) begin
                in_fr[k]    = 1'b0;
                cur_len[k]  = 0;
                cur_bits[k] = 64'd0;
                hi_cnt[k]   = 0;
                miso[k]     = 1'b0;
            end else if (!ss_n[k]) begin
                if (!in_fr[k]) begin
                    in_fr[k]    = 1'b1;
                    cur_len[k]  = 0;
                    cur_bits[k] = 64'd0;
                    gap_len[k]  = hi_cnt[k];
                    fr_seq[k]   = serr[k];
                    fr_start[k]++;
                end
                if (cur_len[k] >= 11 + rw(k) && cur_len[k] < 19 + rw(k))
                    miso[k] = slave_byte[k][7 - (cur_len[k] - 11 - rw(k))];
                else
                    miso[k] = 1'($urandom);
                cur_bits[k] = {cur_bits[k][62:0], mosi[k]};
                cur_len[k]++;
                if (!busy[k]) busy_bad[k]++;
            end else begin
                if (in_fr[k]) begin
                    in_fr[k]        = 1'b0;
                    fr_len[k]       = cur_len[k];
                    fr_bits[k]      = cur_bits[k];
                    fr_rdv_end[k]   = rdv[k];
                    fr_rdd[k]       = rdd[k];
                    fr_ready_end[k] = cready[k];
                    fr_done[k]++;
                    hi_cnt[k] = 0;
                end
                hi_cnt[k]++;
                miso[k] = 1'($urandom);
                if (cready[k] && busy[k]) busy_bad[k]++;
            end
            if (rdv[k]) rdv_cnt[k]++;
            if (serr[k]) seq_cnt[k]++;
        end
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    task automatic wait_ev(input int k, input bit done_ev, input int base, input string nm);
        int cur;
        for (int i = 0; i < 400; i++) begin
            cur = done_ev ? fr_done[k] : fr_start[k];
            if (cur != base) return;
            @(negedge clk);
            #1;
        end
        n_cmp++;
        n_err++;
        $display("FAIL %s: timeout waiting for frame %s on dut%0d", nm, done_ev ? "end" : "start", k);
    endtask

    task automatic issue(input int k, input logic [1:0] t, input logic [7:0] d,
                         input logic [7:0] b, input string nm);
        int s0;
        int d0;
        s0 = fr_start[k];
        d0 = fr_done[k];
        slave_byte[k] = b;
        ctype[k]  = t;
        cdata[k]  = d;
        cvalid[k] = 1'b1;
        wait_ev(k, 1'b0, s0, nm);
        cvalid[k] = 1'b0;
        wait_ev(k, 1'b1, d0, nm);
    endtask

    task automatic check_frame(input int k, input string nm, input int len,
                               input logic [63:0] bits, input logic erdv,
                               input logic [7:0] erdd, input logic eseq,
                               input int rdv0, input int sq0);
        chk({nm, " sslen"}, 64'(fr_len[k]), 64'(len));
        chk({nm, " mosi"}, fr_bits[k], bits);
        chk({nm, " rdv_at_end"}, 64'(fr_rdv_end[k]), 64'(erdv));
        if (erdv) chk({nm, " rd_data"}, 64'(fr_rdd[k]), 64'(erdd));
        chk({nm, " seq_err"}, 64'(fr_seq[k]), 64'(eseq));
        chk({nm, " rdv_pulses"}, 64'(rdv_cnt[k] - rdv0), 64'(erdv));
        chk({nm, " seq_pulses"}, 64'(seq_cnt[k] - sq0), 64'(eseq));
        chk({nm, " ready_after"}, 64'(fr_ready_end[k]), 64'(gp(k) == 1));
    endtask

    // Reference model: frame shape and read result from the command alone
    task automatic model_cmd(input int k, input logic [1:0] t, input logic [7:0] d,
                             input logic [7:0] b, input string nm);
        int rdv0;
        int sq0;
        int len;
        logic [63:0] bits;
        logic es;
        rdv0 = rdv_cnt[k];
        sq0  = seq_cnt[k];
        issue(k, t, d, b, nm);
        len  = (t == 2'b11) ? 11 + rw(k) + 8 : 11;
        bits = 64'({t[1], t, d}) << (len - 11);
        es   = (t == 2'b11) && !pend[k];
        if (t == 2'b10) pend[k] = 1'b1;
        else if (t == 2'b11) pend[k] = 1'b0;
        check_frame(k, nm, len, bits, t == 2'b11, b, es, rdv0, sq0);
    endtask

    task automatic cont_test(input int k);
        logic [1:0] tq [6];
        logic [7:0] dq [6];
        int s0;
        int d0;
        int base;
        for (int i = 0; i < 6; i++) begin
            tq[i] = (i % 2 == 1) ? 2'b01 : 2'b00;
            dq[i] = 8'($urandom);
        end
        base = fr_start[k];
        ctype[k]  = tq[0];
        cdata[k]  = dq[0];
        cvalid[k] = 1'b1;
        for (int i = 0; i < 6; i++) begin
            s0 = fr_start[k];
            wait_ev(k, 1'b0, s0, $sformatf("cont%0d_%0d", k, i));
            if (i < 5) begin
                ctype[k] = tq[i + 1];
                cdata[k] = dq[i + 1];
            end else begin
                cvalid[k] = 1'b0;
            end
            d0 = fr_done[k];
            wait_ev(k, 1'b1, d0, $sformatf("cont%0d_%0d", k, i));
            chk($sformatf("cont%0d_%0d mosi", k, i), fr_bits[k], 64'({tq[i][1], tq[i], dq[i]}));
            chk($sformatf("cont%0d_%0d sslen", k, i), 64'(fr_len[k]), 64'd11);
            if (i > 0) chk($sformatf("cont%0d_%0d gap", k, i), 64'(gap_len[k]), 64'(gp(k)));
        end
        repeat (30) @(negedge clk);
        chk($sformatf("cont%0d frames", k), 64'(fr_start[k] - base), 64'd6);
    endtask

    typedef struct {
        logic [1:0]  t;
        logic [7:0]  d;
        logic [7:0]  b;
        int          len;
        logic [10:0] word;
        logic        erdv;
        logic        eseq;
    } vec_t;

    vec_t tbl [7];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int rdv0;
        int sq0;
        int d0;
        logic [1:0] t;

        tbl[0] = '{2'b00, 8'hA5, 8'h00, 11, 11'h0A5, 1'b0, 1'b0};
        tbl[1] = '{2'b10, 8'h3C, 8'h00, 11, 11'h63C, 1'b0, 1'b0};
        tbl[2] = '{2'b11, 8'h00, 8'hC3, 21, 11'h700, 1'b1, 1'b0};
        tbl[3] = '{2'b11, 8'h5A, 8'h96, 21, 11'h75A, 1'b1, 1'b1};
        tbl[4] = '{2'b01, 8'hFF, 8'h00, 11, 11'h1FF, 1'b0, 1'b0};
        tbl[5] = '{2'b10, 8'h00, 8'h00, 11, 11'h600, 1'b0, 1'b0};
        tbl[6] = '{2'b11, 8'hFF, 8'h00, 21, 11'h7FF, 1'b1, 1'b0};

        rst = 1'b1;
        for (int k = 0; k < 2; k++) begin
            cvalid[k] = 1'b0;
            ctype[k]  = 2'b00;
            cdata[k]  = 8'h00;
        end
        repeat (3) @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            chk($sformatf("rst%0d SS_n", k), 64'(ss_n[k]), 64'd1);
            chk($sformatf("rst%0d MOSI", k), 64'(mosi[k]), 64'd0);
            chk($sformatf("rst%0d cmd_ready", k), 64'(cready[k]), 64'd0);
            chk($sformatf("rst%0d rd_data", k), 64'(rdd[k]), 64'd0);
            chk($sformatf("rst%0d rd_valid", k), 64'(rdv[k]), 64'd0);
            chk($sformatf("rst%0d busy", k), 64'(busy[k]), 64'd0);
            chk($sformatf("rst%0d seq_err", k), 64'(serr[k]), 64'd0);
        end
        rst = 1'b0;
        repeat (5) @(negedge clk);
        #1;
        chk("ready0 after reset gap", 64'(cready[0]), 64'd1);
        chk("ready1 after reset gap", 64'(cready[1]), 64'd1);

        // Table-driven frames on the RD_WAIT=2 / GAP=1 instance
        for (int i = 0; i < 7; i++) begin
            rdv0 = rdv_cnt[0];
            sq0  = seq_cnt[0];
            issue(0, tbl[i].t, tbl[i].d, tbl[i].b, $sformatf("tbl%0d", i));
            check_frame(0, $sformatf("tbl%0d", i), tbl[i].len,
                        64'(tbl[i].word) << (tbl[i].len - 11),
                        tbl[i].erdv, tbl[i].b, tbl[i].eseq, rdv0, sq0);
            if (tbl[i].t == 2'b10) pend[0] = 1'b1;
            else if (tbl[i].t == 2'b11) pend[0] = 1'b0;
        end

        // Reset in the middle of a read response
        model_cmd(0, 2'b10, 8'h11, 8'h00, "pre_abort");
        rdv0 = rdv_cnt[0];
        d0   = fr_done[0];
        slave_byte[0] = 8'hE7;
        ctype[0]  = 2'b11;
        cdata[0]  = 8'h00;
        cvalid[0] = 1'b1;
        wait_ev(0, 1'b0, fr_start[0], "abort");
        cvalid[0] = 1'b0;
        repeat (17) @(negedge clk);
        #3;
        rst = 1'b1;
        #1;
        chk("abort SS_n", 64'(ss_n[0]), 64'd1);
        chk("abort MOSI", 64'(mosi[0]), 64'd0);
        chk("abort rd_valid", 64'(rdv[0]), 64'd0);
        chk("abort rd_data", 64'(rdd[0]), 64'd0);
        chk("abort cmd_ready", 64'(cready[0]), 64'd0);
        chk("abort busy", 64'(busy[0]), 64'd0);
        pend[0] = 1'b0;
        pend[1] = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        chk("abort no rd_valid", 64'(rdv_cnt[0] - rdv0), 64'd0);
        chk("abort no frame end", 64'(fr_done[0] - d0), 64'd0);

        // First command after reset is a read-data with no address: seq_err
        model_cmd(0, 2'b11, 8'h42, 8'h5C, "post_rst_rd");
        model_cmd(0, 2'b00, 8'h81, 8'h00, "post_rst_wr");

        // Randomised commands against the model on both instances
        for (int k = 0; k < 2; k++) begin
            for (int i = 0; i < 15; i++) begin
                t = 2'($urandom_range(0, 3));
                model_cmd(k, t, 8'($urandom), 8'($urandom), $sformatf("rnd%0d_%0d", k, i));
            end
        end

        // Back-to-back commands with cmd_valid held high
        cont_test(0);
        cont_test(1);

        chk("busy0 consistency", 64'(busy_bad[0]), 64'd0);
        chk("busy1 consistency", 64'(busy_bad[1]), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
